mem_copy_dma: RTL and testbench
===============================

MEM_COPY_DMA -- requirements
Module: mem_copy_dma

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, memory word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 5, word-address width (2**ADDR_WIDTH words).
REQ-003 SHALL have port i_clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port i_rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port i_start  input  1  copy request, sampled on rising edge.
REQ-006 SHALL have port i_src  input  ADDR_WIDTH  source start word address.
REQ-007 SHALL have port i_dst  input  ADDR_WIDTH  destination start word address.
REQ-008 SHALL have port i_len  input  ADDR_WIDTH+1  word count, 0..2**ADDR_WIDTH.
REQ-009 SHALL have port o_busy  output  1  high while a copy is in progress.
REQ-010 SHALL have port o_done  output  1  one-cycle completion pulse.
REQ-011 SHALL have port o_addr  output  ADDR_WIDTH  memory word address, to the RAM address input.
REQ-012 SHALL have port o_data  output  DATA_WIDTH  write data, to the RAM data input.
REQ-013 SHALL have port o_we  output  1  write enable, to the RAM write-enable input.
REQ-014 SHALL have port i_mem_data  input  DATA_WIDTH  RAM read data (combinational read of o_addr).

Function
REQ-015 SHALL implement FSM states IDLE, RD, WR, DONE.
REQ-016 SHALL, in IDLE on i_start=1, latch i_src, i_dst, i_len, clear word index, and go to RD if i_len!=0, else DONE.
REQ-017 SHALL ignore i_start in every state other than IDLE; latched parameters remain unchanged.
REQ-018 SHALL, in RD: drive o_addr=src+index, o_we=0; capture i_mem_data into data register at the clock edge; go to WR.
REQ-019 SHALL, in WR: drive o_addr=dst+index, o_data=data register, o_we=1; increment index; go to DONE if index==len-1, else RD.
REQ-020 SHALL, in DONE: assert o_done=1 for exactly one cycle, o_we=0; go to IDLE.
REQ-021 SHALL assert o_busy=1 in RD, WR and DONE, and 0 in IDLE.
REQ-022 SHALL drive o_we=1 only in WR; never two consecutive write cycles.
REQ-023 SHALL compute addresses modulo 2**ADDR_WIDTH (src+index and dst+index wrap, no error).
REQ-024 SHALL copy in ascending index order; overlapping ranges with dst>src replicate the source prefix; this is defined behaviour.
REQ-025 SHALL give latency: start accepted at edge 0; o_done high in cycle 2*len+1; len=0 gives o_done in cycle 1 with no write.
REQ-026 SHALL hold o_addr=0 in IDLE and DONE; o_data always reflects the data register.
REQ-027 SHALL accept a new i_start in the cycle immediately after o_done (back-to-back copies, one IDLE cycle between).
REQ-028 SHALL handle i_len=2**ADDR_WIDTH as a full-memory copy of exactly 2**ADDR_WIDTH words.

Reset
REQ-029 SHALL, on i_rst_n=0, immediately (asynchronously) force state IDLE, o_busy=0, o_done=0, o_we=0, o_addr=0, o_data=0, index=0.
REQ-030 SHALL, on reset mid-copy, abort with no further writes; already-written words stay written; no o_done pulse.
REQ-031 SHALL remain in IDLE after reset release until the next i_start.

Verification
REQ-032 SHALL verify basic copy: RAM[0..3]=A0,A1,A2,A3; start src=0,dst=16,len=4 -> RAM[16..19]=A0..A3, o_done in cycle 9, exactly 4 o_we pulses.
REQ-033 SHALL verify zero length: start len=0 -> o_done in cycle 1, o_we never asserted, o_busy high for one cycle.
REQ-034 SHALL verify wrap: src=30,dst=2,len=4 with ADDR_WIDTH=5 -> reads addresses 30,31,0,1; RAM[2..5] = old RAM[30],RAM[31],RAM[0],RAM[1].
REQ-035 SHALL verify start-while-busy: second i_start with dst=8 during copy -> ignored, no writes to 8, single o_done.
REQ-036 SHALL verify reset mid-copy: len=8, deassert i_rst_n after 2nd write -> o_we=0 at once, only dst+0,dst+1 modified, no o_done.
REQ-037 SHALL verify overlap: RAM[0..3]=1,2,3,4; src=0,dst=1,len=3 -> RAM[0..3]=1,1,1,1.

Source files
------------

// File: rtl/mem_copy_dma.sv
// Word-at-a-time memory-to-memory copy engine driving a single-port RAM with
// combinational read. Each word takes one read cycle followed by one write cycle.
module mem_copy_dma #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_src,
  input  logic [ADDR_WIDTH-1:0] i_dst,
  input  logic [ADDR_WIDTH:0]   i_len,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_we,
  input  logic [DATA_WIDTH-1:0] i_mem_data
);

  localparam logic [ADDR_WIDTH:0] IdxOne = 1;

  typedef enum logic [1:0] {StIdle, StRd, StWr, StDone} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] src_q, src_d;
  logic [ADDR_WIDTH-1:0] dst_q, dst_d;
  logic [ADDR_WIDTH:0]   len_q, len_d;
  logic [ADDR_WIDTH:0]   idx_q, idx_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [ADDR_WIDTH-1:0] idx_lo;

  // Index never exceeds len-1 <= 2**ADDR_WIDTH-1, so the low bits suffice;
  // the address sums wrap naturally at ADDR_WIDTH bits.
  assign idx_lo = idx_q[ADDR_WIDTH-1:0];
  assign o_data = data_q;

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    len_d   = len_q;
    idx_d   = idx_q;
    data_d  = data_q;
    o_busy  = 1'b1;
    o_done  = 1'b0;
    o_we    = 1'b0;
    o_addr  = '0;
    case (state_q)
      StIdle: begin
        o_busy = 1'b0;
        if (i_start) begin
          src_d   = i_src;
          dst_d   = i_dst;
          len_d   = i_len;
          idx_d   = '0;
          state_d = (i_len != '0) ? StRd : StDone;
        end
      end
      StRd: begin
        o_addr  = src_q + idx_lo;
        data_d  = i_mem_data;
        state_d = StWr;
      end
      StWr: begin
        o_addr  = dst_q + idx_lo;
        o_we    = 1'b1;
        idx_d   = idx_q + IdxOne;
        state_d = (idx_q == len_q - IdxOne) ? StDone : StRd;
      end
      StDone: begin
        o_done  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= StIdle;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: tb/tb_mem_copy_dma.sv
// Bench for mem_copy_dma: behavioural RAM plus a sequential word-copy reference model.
module tb_mem_copy_dma;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int N  = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] src, dst;
  logic [AW:0]   len;
  logic          busy, done, we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata, mem_data;

  logic [DW-1:0] ram   [N];
  logic [DW-1:0] img   [N];
  logic [DW-1:0] model [N];
  logic          load;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  mem_copy_dma #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_start    (start),
    .i_src      (src),
    .i_dst      (dst),
    .i_len      (len),
    .o_busy     (busy),
    .o_done     (done),
    .o_addr     (addr),
    .o_data     (wdata),
    .o_we       (we),
    .i_mem_data (mem_data)
  );

  assign mem_data = ram[addr];

  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < N; i++) ram[i] <= img[i];
    end else if (we) begin
      ram[addr] <= wdata;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load_img();
    model = img;
    @(negedge clk);
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic randomize_img();
    for (int i = 0; i < N; i++) img[i] = $urandom;
  endtask

  // Reference: words copied one after another in ascending order, addresses mod N.
  task automatic model_copy(input int s, input int d, input int l);
    for (int i = 0; i < l; i++) model[(d + i) % N] = model[(s + i) % N];
  endtask

  task automatic check_mem(input string tag);
    for (int i = 0; i < N; i++) chk($sformatf("%s mem[%0d]", tag, i), ram[i], model[i]);
  endtask

  // Issue one copy; poke>0 raises a second i_start (dst=8) in that cycle of the copy.
  task automatic run_copy(input string tag, input int s, input int d, input int l,
                          input int poke);
    int we_cnt   = 0;
    int done_cyc = -1;
    @(negedge clk);
    chk({tag, " idle before start"}, busy, 0);
    start = 1'b1;
    src   = AW'(s);
    dst   = AW'(d);
    len   = (AW + 1)'(l);
    model_copy(s, d, l);
    for (int c = 1; c <= 2 * N + 8 && done_cyc < 0; c++) begin
      @(negedge clk);
      start = (c == poke);
      if (c == poke) begin
        src = AW'(0);
        dst = AW'(8);
        len = (AW + 1)'(8);
      end
      if (we) we_cnt++;
      if (done) done_cyc = c;
      if (c <= 2 * l) begin
        chk($sformatf("%s busy c%0d", tag, c), busy, 1);
        chk($sformatf("%s we c%0d", tag, c), we, (c % 2 == 0));
        chk($sformatf("%s addr c%0d", tag, c), addr,
            (c % 2 == 1) ? (s + (c - 1) / 2) % N : (d + c / 2 - 1) % N);
      end
    end
    chk({tag, " done cycle"}, done_cyc, 2 * l + 1);
    chk({tag, " write count"}, we_cnt, l);
    chk({tag, " busy in done"}, busy, 1);
    chk({tag, " we in done"}, we, 0);
    chk({tag, " addr in done"}, addr, 0);
    check_mem(tag);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    load  = 1'b0;
    src   = '0;
    dst   = '0;
    len   = '0;
    #12;
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset we", we, 0);
    chk("reset addr", addr, 0);
    chk("reset data", wdata, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle after reset busy", busy, 0);
      chk("idle after reset we", we, 0);
    end

    // Basic copy of four known words
    randomize_img();
    for (int i = 0; i < 4; i++) img[i] = 32'hA0 + i;
    load_img();
    run_copy("basic", 0, 16, 4, 0);
    for (int i = 0; i < 4; i++) chk($sformatf("basic const %0d", i), ram[16 + i], 32'hA0 + i);

    run_copy("zero_len", 7, 9, 0, 0);

    randomize_img();
    load_img();
    run_copy("wrap", 30, 2, 4, 0);

    randomize_img();
    load_img();
    run_copy("busy_poke", 1, 20, 4, 3);
    @(negedge clk);
    chk("busy_poke no second done", done, 0);
    chk("busy_poke idle", busy, 0);

    img[0] = 1;
    img[1] = 2;
    img[2] = 3;
    img[3] = 4;
    load_img();
    run_copy("overlap", 0, 1, 3, 0);
    for (int i = 0; i < 4; i++) chk($sformatf("overlap const %0d", i), ram[i], 1);

    randomize_img();
    load_img();
    run_copy("full", 3, 10, 32, 0);

    // Back-to-back and randomized copies without gaps
    randomize_img();
    load_img();
    for (int k = 0; k < 5; k++) begin
      run_copy($sformatf("rand%0d", k), $urandom_range(N - 1), $urandom_range(N - 1),
               $urandom_range(N), 0);
    end

    // Reset in the middle of a copy, right after the second write
    randomize_img();
    load_img();
    @(negedge clk);
    start = 1'b1;
    src   = AW'(0);
    dst   = AW'(12);
    len   = (AW + 1)'(8);
    model_copy(0, 12, 2);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_mid we before abort", we, 1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid we", we, 0);
    chk("rst_mid busy", busy, 0);
    chk("rst_mid addr", addr, 0);
    chk("rst_mid data", wdata, 0);
    chk("rst_mid done", done, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_mid held we", we, 0);
      chk("rst_mid held done", done, 0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rst_mid released busy", busy, 0);
      chk("rst_mid released done", done, 0);
    end
    check_mem("rst_mid");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
